// File: rtl/sync_gray_pkg.sv
// rtl/sync_gray_pkg.sv - shared limits and gray/binary helpers for pointer synchronisers
package sync_gray_pkg;

    localparam int STAGES_MIN = 2;
    localparam int STAGES_MAX = 4;
    localparam int MAX_WIDTH  = 16;

    function automatic logic [MAX_WIDTH-1:0] gray2bin(input logic [MAX_WIDTH-1:0] g);
        logic [MAX_WIDTH-1:0] b;
        b[MAX_WIDTH-1] = g[MAX_WIDTH-1];
        for (int i = MAX_WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [4:0] popcount(input logic [MAX_WIDTH-1:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            n = n + {4'b0000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/sync_gray_chain.sv
// rtl/sync_gray_chain.sv - generic multi-flop clock-domain-crossing chain (module sync_chain)
module sync_chain
    import sync_gray_pkg::*;
#(
    parameter int               WIDTH     = 1,
    parameter int               STAGES    = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
        $error("sync_chain: STAGES out of range 2..4");
    end

    // Plain flop-to-flop path only; any logic here would break metastability settling.
    (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] s [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                s[i] <= RESET_VAL;
            end
        end else begin
            s[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                s[i] <= s[i-1];
            end
        end
    end

    assign q = s[STAGES-1];

endmodule

// File: rtl/sync_gray_ptr.sv
// rtl/sync_gray_ptr.sv - gray pointer synchroniser with binary view, advance delta and step checker
module sync_gray_ptr
    import sync_gray_pkg::*;
#(
    parameter int               WIDTH     = 5,
    parameter int               STAGES    = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] async_gray_in,
    input  logic             err_clr,
    output logic [WIDTH-1:0] sync_gray_out,
    output logic [WIDTH-1:0] sync_bin_out,
    output logic             changed,
    output logic [WIDTH-1:0] delta,
    output logic             err_multi_bit
);

    if (WIDTH < 2 || WIDTH > MAX_WIDTH) begin : g_bad_width
        $error("sync_gray_ptr: WIDTH out of range 2..16");
    end

    localparam logic [WIDTH-1:0] RESET_BIN = WIDTH'(gray2bin(MAX_WIDTH'(RESET_VAL)));

    logic [WIDTH-1:0] g_prev;
    logic [WIDTH-1:0] cur_bin;
    logic [WIDTH-1:0] prev_bin;
    logic             step;
    logic             multi;

    sync_chain #(
        .WIDTH     (WIDTH),
        .STAGES    (STAGES),
        .RESET_VAL (RESET_VAL)
    ) u_chain (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (async_gray_in),
        .q     (sync_gray_out)
    );

    assign cur_bin  = WIDTH'(gray2bin(MAX_WIDTH'(sync_gray_out)));
    assign prev_bin = WIDTH'(gray2bin(MAX_WIDTH'(g_prev)));
    assign step     = (sync_gray_out != g_prev);
    assign multi    = (popcount(MAX_WIDTH'(sync_gray_out ^ g_prev)) > 5'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            g_prev        <= RESET_VAL;
            sync_bin_out  <= RESET_BIN;
            changed       <= 1'b0;
            delta         <= '0;
            err_multi_bit <= 1'b0;
        end else begin
            g_prev       <= sync_gray_out;
            sync_bin_out <= cur_bin;
            changed      <= step;
            // Modulo subtraction makes the wrap from all-ones to zero read as +1.
            delta        <= step ? (cur_bin - prev_bin) : '0;
            if (step && multi) begin
                err_multi_bit <= 1'b1;
            end else if (err_clr) begin
                err_multi_bit <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sync_gray_ptr.sv
// tb/tb_sync_gray_ptr.sv - scoreboard bench for sync_gray_ptr
module tb_sync_gray_ptr;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       err_clr = 1'b0;
    logic [4:0] gin = 5'd0;
    logic [4:0] sgo, sbo, dlt;
    logic       chg, err;

    logic [7:0] g8 = 8'd0;
    logic [7:0] sgo8, sbo8, dlt8;
    logic       chg8, err8;

    typedef struct {
        logic [4:0] bin;
        logic [4:0] delta;
        logic       err;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    sync_gray_ptr #(.WIDTH(5), .STAGES(2), .RESET_VAL(5'd0)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .async_gray_in (gin),
        .err_clr       (err_clr),
        .sync_gray_out (sgo),
        .sync_bin_out  (sbo),
        .changed       (chg),
        .delta         (dlt),
        .err_multi_bit (err)
    );

    sync_gray_ptr #(.WIDTH(8), .STAGES(3), .RESET_VAL(8'd0)) dut8 (
        .clk           (clk),
        .rst_n         (rst_n),
        .async_gray_in (g8),
        .err_clr       (1'b0),
        .sync_gray_out (sgo8),
        .sync_bin_out  (sbo8),
        .changed       (chg8),
        .delta         (dlt8),
        .err_multi_bit (err8)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input logic [4:0] b, input logic [4:0] d, input logic e);
        exp_t x;
        x.bin   = b;
        x.delta = d;
        x.err   = e;
        sb.push_back(x);
    endtask

    // Monitor: every changed pulse must match the oldest expected entry.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (chg) begin
                if (sb.size() == 0) begin
                    check("unexpected_changed", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("bin", 32'(sbo), 32'(e.bin));
                    check("delta", 32'(dlt), 32'(e.delta));
                    check("err_at_change", 32'(err), 32'(e.err));
                end
            end else begin
                check("delta_idle", 32'(dlt), 32'd0);
            end
        end
    end

    initial begin
        logic [4:0] v;

        // Reset with a non-reset input present
        rst_n = 1'b0;
        gin   = 5'b10110;
        repeat (2) @(negedge clk);
        check("rst_gray", 32'(sgo), 32'd0);
        check("rst_bin", 32'(sbo), 32'd0);
        check("rst_changed", 32'(chg), 32'd0);
        check("rst_delta", 32'(dlt), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        push(5'd27, 5'd27, 1'b1);
        @(negedge clk);
        check("lat_e1_gray", 32'(sgo), 32'd0);
        @(negedge clk);
        check("lat_e2_gray", 32'(sgo), 32'b10110);
        check("lat_e2_bin", 32'(sbo), 32'd0);
        @(negedge clk);
        check("lat_e3_bin", 32'(sbo), 32'd27);
        check("lat_e3_changed", 32'(chg), 32'd1);
        @(negedge clk);
        check("lat_e4_changed", 32'(chg), 32'd0);
        check("err_sticky", 32'(err), 32'd1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("err_cleared", 32'(err), 32'd0);

        // Re-reset with zero input so the count starts at the reset value
        rst_n = 1'b0;
        gin   = 5'd0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Count 1..31, 0, 1: one gray step per edge
        for (int i = 1; i <= 33; i++) begin
            v = 5'(i % 32);
            gin = v ^ (v >> 1);
            push(v, 5'd1, 1'b0);
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
        check("count_drained", 32'(sb.size()), 32'd0);
        check("count_err", 32'(err), 32'd0);

        // Skip: gray 00001 (bin 1) -> 00010 (bin 3)
        gin = 5'b00010;
        push(5'd3, 5'd2, 1'b1);
        repeat (4) @(negedge clk);
        check("skip_err", 32'(err), 32'd1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("skip_clr", 32'(err), 32'd0);

        // Violation and clear on the same edge: bin 3 -> 5 flips two gray bits
        gin = 5'b00111;
        push(5'd5, 5'd2, 1'b1);
        @(negedge clk);
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("set_wins", 32'(err), 32'd1);
        @(negedge clk);
        check("set_wins_hold", 32'(err), 32'd1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("clr_again", 32'(err), 32'd0);

        // Hold for 20 cycles
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("hold_gray", 32'(sgo), 32'b00111);
            check("hold_err", 32'(err), 32'd0);
        end

        // Resume counting from 5, then reset mid-cycle
        for (int i = 6; i <= 12; i++) begin
            v = 5'(i);
            gin = v ^ (v >> 1);
            push(v, 5'd1, 1'b0);
            @(negedge clk);
        end
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("midrst_gray", 32'(sgo), 32'd0);
        check("midrst_bin", 32'(sbo), 32'd0);
        check("midrst_changed", 32'(chg), 32'd0);
        check("midrst_delta", 32'(dlt), 32'd0);
        check("midrst_err", 32'(err), 32'd0);
        gin = 5'd0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 1; i <= 4; i++) begin
            v = 5'(i);
            gin = v ^ (v >> 1);
            push(v, 5'd1, 1'b0);
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
        check("resume_drained", 32'(sb.size()), 32'd0);
        check("resume_err", 32'(err), 32'd0);

        // Three-stage, 8-bit instance: single step 0 -> 1
        g8 = 8'd1;
        @(negedge clk);
        check("s3_e1_gray", 32'(sgo8), 32'd0);
        @(negedge clk);
        check("s3_e2_gray", 32'(sgo8), 32'd0);
        @(negedge clk);
        check("s3_e3_gray", 32'(sgo8), 32'd1);
        check("s3_e3_bin", 32'(sbo8), 32'd0);
        check("s3_e3_changed", 32'(chg8), 32'd0);
        @(negedge clk);
        check("s3_e4_bin", 32'(sbo8), 32'd1);
        check("s3_e4_changed", 32'(chg8), 32'd1);
        check("s3_e4_delta", 32'(dlt8), 32'd1);
        @(negedge clk);
        check("s3_e5_changed", 32'(chg8), 32'd0);
        check("s3_err", 32'(err8), 32'd0);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
